pipelined_add_sub: RTL and testbench
====================================

Name: pipelined_add_sub

Overview:
Parametrised, pipelined carry-chain adder/subtractor that supersedes the single-cycle combinational ripple adder.
- The WIDTH-bit operation is split into STAGES equal chunks. Each chunk's carry is registered between stages, so critical-path length scales with WIDTH/STAGES.
- Adds subtract mode, signed-overflow detection and a valid/ready stream interface, sustaining one operation per cycle.
- Sits between operand-producing datapath logic and result consumers that may apply backpressure.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages (1..WIDTH); each stage resolves CHUNK = WIDTH/STAGES bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands/mode valid this cycle
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: a+b+cin; 1: a-b-cin
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry-out (add); NOT borrow (sub: 1 = no borrow)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Single clock; reset is synchronous and active-high. While rst=1 at a rising edge, all stage valid bits, out_valid, sum, cout and overflow clear to 0. in_ready is forced 0 while rst=1.
- Operand transform at input: b_eff = sub ? ~b : b; c_eff = sub ? ~cin : cin. The result is a + b_eff + c_eff, mod 2^WIDTH.
- Stage k (0..STAGES-1) adds chunk k of a and b_eff with the carry from stage k-1 (c_eff for k=0). It registers:
  - the chunk sum, appended to the lower result bits;
  - the carry;
  - the valid bit;
  - the still-unprocessed upper operand chunks (input skew);
  - stage STAGES-1 also registers the carry into bit WIDTH-1.
- Outputs are driven directly from the final stage registers; no combinational path from a/b to sum.
- Results: cout = carry out of bit WIDTH-1; overflow = carry into bit WIDTH-1 XOR cout.
- Pipeline advance: adv = !out_valid | out_ready. in_ready = adv (and !rst). All stages shift together only when adv=1; otherwise every stage holds (global stall).
- Accept: an operation is accepted at a rising edge where in_valid & in_ready.
  - Accepted in cycle t with no stall: out_valid=1 with its result in cycle t+STAGES (latency STAGES).
  - Each stalled cycle adds one cycle of latency.
- Bubbles: if in_valid=0 on an advancing edge, stage 0 loads valid=0. Bubbles flow through and never produce out_valid.
- A result is consumed on an edge with out_valid & out_ready. Throughput is 1 op/cycle when out_ready is held high.
- Output stability: while out_valid=1 & out_ready=0, sum/cout/overflow/out_valid are held stable.
- Ordering: results emerge strictly in acceptance order. No loss, no duplication.
- Simultaneous events: consume and accept on the same edge are both performed.
- Reset mid-operation: all in-flight operations are discarded. No stale result appears after reset deasserts.
- Gating: inputs are ignored when in_valid=0 or in_ready=0.
- STAGES=1 degenerates to a single registered WIDTH-bit stage with latency 1.

Test Plan:
1. W=16,S=4: add 0xFFFF + 0x0001, cin=0, out_ready=1 -> sum=0x0000, cout=1, overflow=0, out_valid exactly 4 cycles after accept.
2. Add 0x7FFF + 0x0001 -> sum=0x8000, cout=0, overflow=1. Add 0x1234 + 0x0F0F with cin=1 -> sum=0x2144, cout=0, overflow=0.
3. Subtract cases:
   - sub=1, 0x0005 - 0x0007, cin=0 -> 0xFFFE, cout=0, overflow=0.
   - sub=1, 0x8000 - 0x0001 -> 0x7FFF, cout=1, overflow=1.
   - sub=1, 0x0010 - 0x0003, cin=1 -> 0x000C, cout=1.
4. Backpressure:
   - Stimulus: 8 back-to-back ops with in_valid held high; out_ready low for 3 cycles once the first result is valid.
   - Required: in_ready=0 during the stall and the held output is unchanged.
   - Required: all 8 results appear in order with no duplicates, and a 1-op/cycle gap-free stream resumes after the stall.
5. Reset and interleaving:
   - Accept 3 ops, assert rst for 1 cycle mid-flight -> out_valid=0 the following cycle, and no result from those 3 ever appears.
   - The next op after reset gives a correct result after 4 cycles.
6. Configs W=8,S=1 and W=32,S=8, with 1000 random ops, random in_valid/out_ready and random sub -> every result matches the reference model (a ± b ± cin, cout, overflow), and the latency equals STAGES plus stall cycles.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// Pipelined carry-chain adder/subtractor with a valid/ready stream interface.
// Each stage resolves one CHUNK of the result and registers its carry for the next stage.
module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             adv_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c_eff_s;
    logic             msb_carry_s;

    logic [WIDTH-1:0]  a_in_s      [STAGES];
    logic [WIDTH-1:0]  b_in_s      [STAGES];
    logic [WIDTH-1:0]  s_in_s      [STAGES];
    logic [WIDTH-1:0]  s_next_s    [STAGES];
    logic [CHUNK-1:0]  chunk_sum_s [STAGES];
    logic [STAGES-1:0] c_in_s;
    logic [STAGES-1:0] v_in_s;
    logic [STAGES-1:0] c_out_s;

    logic [WIDTH-1:0]  a_r   [STAGES];
    logic [WIDTH-1:0]  b_r   [STAGES];
    logic [WIDTH-1:0]  sum_r [STAGES];
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] carry_r;
    logic              ovf_r;

    // Global stall: the whole pipe moves only when the output slot can be freed.
    assign adv_s    = !valid_r[STAGES-1] || out_ready;
    assign in_ready = adv_s && !rst;

    // Subtraction is a + ~b + ~borrow, so cout reads as NOT borrow.
    assign b_eff_s = sub ? ~b : b;
    assign c_eff_s = sub ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign a_in_s[k] = a;
            assign b_in_s[k] = b_eff_s;
            assign s_in_s[k] = {WIDTH{1'b0}};
            assign c_in_s[k] = c_eff_s;
            assign v_in_s[k] = in_valid;
        end else begin : g_next
            assign a_in_s[k] = a_r[k-1];
            assign b_in_s[k] = b_r[k-1];
            assign s_in_s[k] = sum_r[k-1];
            assign c_in_s[k] = carry_r[k-1];
            assign v_in_s[k] = valid_r[k-1];
        end

        assign {c_out_s[k], chunk_sum_s[k]} = {1'b0, a_in_s[k][k*CHUNK +: CHUNK]}
                                            + {1'b0, b_in_s[k][k*CHUNK +: CHUNK]}
                                            + {{CHUNK{1'b0}}, c_in_s[k]};
        assign s_next_s[k] = s_in_s[k] | (WIDTH'(chunk_sum_s[k]) << (k * CHUNK));
    end

    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
    assign msb_carry_s = s_next_s[STAGES-1][WIDTH-1]
                       ^ a_in_s[STAGES-1][WIDTH-1]
                       ^ b_in_s[STAGES-1][WIDTH-1];

    // Stage registers: clear on reset, shift together on advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= 1'b0;
                carry_r[k] <= 1'b0;
                sum_r[k]   <= {WIDTH{1'b0}};
                a_r[k]     <= {WIDTH{1'b0}};
                b_r[k]     <= {WIDTH{1'b0}};
            end
            ovf_r <= 1'b0;
        end else if (adv_s) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= v_in_s[k];
                carry_r[k] <= c_out_s[k];
                sum_r[k]   <= s_next_s[k];
                a_r[k]     <= a_in_s[k];
                b_r[k]     <= b_in_s[k];
            end
            ovf_r <= msb_carry_s ^ c_out_s[STAGES-1];
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign sum       = sum_r[STAGES-1];
    assign cout      = carry_r[STAGES-1];
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed and random self-checking bench for pipelined_add_sub
// (instances: 16-bit/4 stages, 8-bit/1 stage, 32-bit/8 stages).
module tb_pipelined_add_sub;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  ird;
    logic [2:0]  ovd;
    logic [2:0]  co;
    logic [2:0]  ov;
    logic [15:0] sum0;
    logic [7:0]  sum1;
    logic [31:0] sum2;

    int checks;
    int failures;

    localparam logic [15:0] BP_EXP [8] = '{16'h0001, 16'h1112, 16'h2223, 16'h3334,
                                           16'h4445, 16'h5556, 16'h6667, 16'h7778};

    pipelined_add_sub #(.WIDTH(16), .STAGES(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ird[0]),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(ovd[0]), .out_ready(ordy[0]), .sum(sum0), .cout(co[0]), .overflow(ov[0]));

    pipelined_add_sub #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ird[1]),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .out_valid(ovd[1]), .out_ready(ordy[1]), .sum(sum1), .cout(co[1]), .overflow(ov[1]));

    pipelined_add_sub #(.WIDTH(32), .STAGES(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ird[2]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ovd[2]), .out_ready(ordy[2]), .sum(sum2), .cout(co[2]), .overflow(ov[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get_sum(input int k);
        case (k)
            0:       return {16'h0000, sum0};
            1:       return {24'h000000, sum1};
            default: return sum2;
        endcase
    endfunction

    // Issue one op on the 16-bit instance into an idle pipe; returns result and edges to out_valid.
    task automatic run_single(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                              input logic ts, output logic [17:0] res, output int lat);
        @(negedge clk);
        a = {16'h0000, ta}; b = {16'h0000, tb_}; cin = tc; sub = ts;
        iv[0] = 1'b1; ordy[0] = 1'b1;
        lat = -1;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            iv[0] = 1'b0;
            if (ovd[0]) begin
                lat = n;
                break;
            end
            @(posedge clk);
        end
        res = {sum0, co[0], ov[0]};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ovd, ird, co, ov} !== 12'h000) begin
            failures++;
            $display("FAIL reset_ctrl: got ovd/ird/co/ov=%h expected 000", {ovd, ird, co, ov});
        end
        checks++;
        if ({sum0, sum1, sum2} !== 56'h0) begin
            failures++;
            $display("FAIL reset_sum: got %h expected 0", {sum0, sum1, sum2});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ird !== 3'b111) begin
            failures++;
            $display("FAIL reset_release_ready: got %b expected 111", ird);
        end
    endtask

    task automatic test_add;
        logic [17:0] r;
        int lat;
        run_single(16'hFFFF, 16'h0001, 1'b0, 1'b0, r, lat);
        checks++;
        if (r !== {16'h0000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL add_wrap: got %h expected %h", r, {16'h0000, 1'b1, 1'b0});
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL add_latency: got %0d expected 4", lat);
        end
        run_single(16'h7FFF, 16'h0001, 1'b0, 1'b0, r, lat);
        checks++;
        if (r !== {16'h8000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL add_overflow: got %h expected %h", r, {16'h8000, 1'b0, 1'b1});
        end
        run_single(16'h1234, 16'h0F0F, 1'b1, 1'b0, r, lat);
        checks++;
        if (r !== {16'h2144, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add_cin: got %h expected %h", r, {16'h2144, 1'b0, 1'b0});
        end
    endtask

    task automatic test_sub;
        logic [17:0] r;
        int lat;
        run_single(16'h0005, 16'h0007, 1'b0, 1'b1, r, lat);
        checks++;
        if (r !== {16'hFFFE, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL sub_borrow: got %h expected %h", r, {16'hFFFE, 1'b0, 1'b0});
        end
        run_single(16'h8000, 16'h0001, 1'b0, 1'b1, r, lat);
        checks++;
        if (r !== {16'h7FFF, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL sub_overflow: got %h expected %h", r, {16'h7FFF, 1'b1, 1'b1});
        end
        run_single(16'h0010, 16'h0003, 1'b1, 1'b1, r, lat);
        checks++;
        if (r !== {16'h000C, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub_borrow_in: got %h expected %h", r, {16'h000C, 1'b1, 1'b0});
        end
    endtask

    task automatic test_back_to_back;
        int nxt = 0;
        int got = 0;
        int stall_left = 3;
        bit stall_seen = 1'b0;
        for (int it = 0; it < 40 && got < 8; it++) begin
            @(negedge clk);
            if (nxt < 8) begin
                iv[0] = 1'b1;
                a = 32'h1111 * nxt;
                b = 32'h0001; cin = 1'b0; sub = 1'b0;
            end else begin
                iv[0] = 1'b0;
            end
            if (ovd[0] && stall_left > 0) begin
                ordy[0] = 1'b0;
                stall_left--;
                stall_seen = 1'b1;
            end else begin
                ordy[0] = 1'b1;
            end
            #1;
            if (!ordy[0]) begin
                checks++;
                if ({ird[0], ovd[0], sum0} !== {1'b0, 1'b1, 16'h0001}) begin
                    failures++;
                    $display("FAIL bp_stall_hold: got rdy/vld/sum=%h expected %h",
                             {ird[0], ovd[0], sum0}, {1'b0, 1'b1, 16'h0001});
                end
            end else if (stall_seen) begin
                checks++;
                if (ovd[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_gap_free: got out_valid=%b expected 1 at result %0d", ovd[0], got);
                end
            end
            if (ovd[0] && ordy[0]) begin
                checks++;
                if (sum0 !== BP_EXP[got]) begin
                    failures++;
                    $display("FAIL bp_order: got %h expected %h at result %0d", sum0, BP_EXP[got], got);
                end
                got++;
            end
            if (iv[0] && ird[0]) nxt++;
            @(posedge clk);
        end
        checks++;
        if (got !== 8) begin
            failures++;
            $display("FAIL bp_count: got %0d expected 8", got);
        end
        @(negedge clk);
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        checks++;
        if (ovd[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_dup: got out_valid=%b expected 0", ovd[0]);
        end
    endtask

    task automatic test_reset_midflight;
        logic [17:0] r;
        int lat;
        int seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            iv[0] = 1'b1; ordy[0] = 1'b1;
            a = 32'h0100 + i; b = 32'h0011; cin = 1'b0; sub = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        iv[0] = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (ird[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_ready: got %b expected 0", ird[0]);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ovd[0], sum0} !== 17'h0) begin
            failures++;
            $display("FAIL rst_flush: got vld/sum=%h expected 0", {ovd[0], sum0});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ovd[0]) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_stale: got %0d stale results expected 0", seen);
        end
        run_single(16'h0003, 16'h0004, 1'b0, 1'b0, r, lat);
        checks++;
        if ({r, lat[3:0]} !== {16'h0007, 1'b0, 1'b0, 4'd4}) begin
            failures++;
            $display("FAIL rst_next_op: got %h lat %0d expected 0007/0/0 lat 4", r, lat);
        end
    endtask

    // Random stream on instance k against an arithmetic reference and a latency model.
    task automatic test_random(input int k, input int w, input int s, input int n);
        logic [33:0] q_res [$];
        int          q_cyc [$];
        int          q_snap[$];
        logic [63:0] m, am, be, full, half;
        logic        ce;
        logic [33:0] exp_r;
        int n_acc = 0;
        int stalls = 0;
        int cyc = 0;
        int bad = 0;
        m = (64'd1 << w) - 64'd1;
        for (int it = 0; it < 20000 && !(n_acc >= n && q_res.size() == 0); it++) begin
            @(negedge clk);
            iv[k]   = (n_acc < n) && ($urandom_range(0, 9) < 7);
            ordy[k] = (n_acc >= n) || ($urandom_range(0, 9) < 7);
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            #1;
            if (ovd[k] && ordy[k]) begin
                checks++;
                if (q_res.size() == 0) begin
                    failures++;
                    $display("FAIL rnd%0d_spurious: got result %h expected none", k, get_sum(k));
                end else begin
                    exp_r = q_res.pop_front();
                    if ({get_sum(k), co[k], ov[k]} !== exp_r) begin
                        failures++;
                        if (bad++ < 5)
                            $display("FAIL rnd%0d_result: got %h expected %h", k,
                                     {get_sum(k), co[k], ov[k]}, exp_r);
                    end
                    checks++;
                    if (cyc - q_cyc[0] !== s + stalls - q_snap[0]) begin
                        failures++;
                        if (bad++ < 5)
                            $display("FAIL rnd%0d_latency: got %0d expected %0d", k,
                                     cyc - q_cyc[0], s + stalls - q_snap[0]);
                    end
                    void'(q_cyc.pop_front());
                    void'(q_snap.pop_front());
                end
            end
            if (iv[k] && ird[k]) begin
                am = {32'h0, a} & m;
                be = (sub ? ~{32'h0, b} : {32'h0, b}) & m;
                ce = sub ^ cin;
                full = am + be + {63'h0, ce};
                half = (am & (m >> 1)) + (be & (m >> 1)) + {63'h0, ce};
                q_res.push_back({full[31:0] & m[31:0], full[w], half[w-1] ^ full[w]});
                q_cyc.push_back(cyc);
                q_snap.push_back(stalls);
                n_acc++;
            end
            if (ovd[k] && !ordy[k]) stalls++;
            cyc++;
            @(posedge clk);
        end
        @(negedge clk);
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        checks++;
        if ({n_acc, q_res.size()} !== {n, 32'd0}) begin
            failures++;
            $display("FAIL rnd%0d_drain: got accepted %0d pending %0d expected %0d/0",
                     k, n_acc, q_res.size(), n);
        end
        checks++;
        if (ovd[k] !== 1'b0) begin
            failures++;
            $display("FAIL rnd%0d_no_extra: got out_valid=%b expected 0", k, ovd[k]);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        iv = 3'b000;
        ordy = 3'b111;
        a = 32'h0; b = 32'h0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_midflight();
        test_random(1, 8, 1, 1000);
        test_random(2, 32, 8, 1000);
        test_random(0, 16, 4, 500);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
